// File: rtl/symbol_upsampler.sv
// BPSK symbol upsampler: bytes in over valid/ready, MSB-first impulses of +/-AMPLITUDE out,
// each followed by SAMPLES_PER_SYMBOL-1 zeros. Define SYMBOL_UPSAMPLER_DIFF_EN for differential encoding.
//
// state   | meaning
// S_IDLE  | no byte in progress, output zero, ready once armed
// S_SHIFT | emitting samples of the held byte, one per clock
module symbol_upsampler #(
    parameter int WIDTH              = 12,
    parameter int SAMPLES_PER_SYMBOL = 4,
    parameter int AMPLITUDE          = 2047
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [WIDTH-1:0] out,
    output logic                    out_strobe,
    output logic                    busy
);

    localparam int PW = (SAMPLES_PER_SYMBOL > 2) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(SAMPLES_PER_SYMBOL - 1);
    localparam logic signed [WIDTH-1:0] AMP_POS = WIDTH'(AMPLITUDE);
    localparam logic signed [WIDTH-1:0] AMP_NEG = WIDTH'(-AMPLITUDE);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              byte_q, byte_d;
    logic [2:0]              bit_idx_q, bit_idx_d;
    logic [PW-1:0]           phase_q, phase_d;
    logic                    armed_q;
    logic signed [WIDTH-1:0] out_q, out_d;
    logic                    strobe_q, strobe_d;

    logic emit;
    logic data_bit;
    logic sym;
    logic last_slot;
    logic ready_c;
    logic accept;

    assign last_slot = (bit_idx_q == 3'd0) && (phase_q == PH_LAST);
    assign ready_c   = armed_q && ((state_q == S_IDLE) || last_slot);
    assign accept    = in_valid && ready_c;

`ifdef SYMBOL_UPSAMPLER_DIFF_EN
    logic prev_q, prev_d;

    assign sym = data_bit ^ prev_q;

    // Previous symbol survives idle gaps; only reset clears it.
    always_comb begin
        prev_d = prev_q;
        if (emit) begin
            prev_d = sym;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end
`else
    assign sym = data_bit;
`endif

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        bit_idx_d = bit_idx_q;
        phase_d   = phase_q;
        emit      = 1'b0;
        data_bit  = 1'b0;

        if (accept) begin
            // Covers both the idle start and the seamless follow-on at end of byte.
            state_d   = S_SHIFT;
            byte_d    = in_data;
            bit_idx_d = 3'd7;
            phase_d   = '0;
            emit      = 1'b1;
            data_bit  = in_data[7];
        end else if (state_q == S_SHIFT) begin
            if (phase_q != PH_LAST) begin
                phase_d = phase_q + PW'(1);
            end else if (bit_idx_q != 3'd0) begin
                phase_d   = '0;
                bit_idx_d = bit_idx_q - 3'd1;
                emit      = 1'b1;
                data_bit  = byte_q[bit_idx_d];
            end else begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        end
    end

    always_comb begin
        out_d    = '0;
        strobe_d = 1'b0;
        if (emit) begin
            out_d    = sym ? AMP_POS : AMP_NEG;
            strobe_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            byte_q    <= '0;
            bit_idx_q <= '0;
            phase_q   <= '0;
            armed_q   <= 1'b0;
            out_q     <= '0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            bit_idx_q <= bit_idx_d;
            phase_q   <= phase_d;
            armed_q   <= 1'b1;
            out_q     <= out_d;
            strobe_q  <= strobe_d;
        end
    end

    assign in_ready   = ready_c;
    assign busy       = (state_q == S_SHIFT);
    assign out        = out_q;
    assign out_strobe = strobe_q;

endmodule

// File: tb/tb_symbol_upsampler.sv
// Directed bench for symbol_upsampler: reset, idle, single byte, back-to-back, mid-byte reset,
// and the differential-encoding sequence (expectations follow SYMBOL_UPSAMPLER_DIFF_EN).
module tb_symbol_upsampler;

    localparam int W   = 12;
    localparam int SPS = 4;
    localparam int AMP = 2047;
    localparam int BYTE_CYC = 8 * SPS;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [7:0]          in_data = 8'h00;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] out;
    logic                out_strobe;
    logic                busy;

    int n_pass  = 0;
    int n_total = 0;
    bit ref_prev = 1'b0;

    always #5 clk = ~clk;

    symbol_upsampler #(
        .WIDTH(W),
        .SAMPLES_PER_SYMBOL(SPS),
        .AMPLITUDE(AMP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out(out),
        .out_strobe(out_strobe),
        .busy(busy)
    );

    task automatic chk(input string tag, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input int want_ready);
        chk({tag, "_out"}, int'(out), 0);
        chk({tag, "_strobe"}, int'(out_strobe), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_ready"}, int'(in_ready), want_ready);
    endtask

    // Expected sample for cycle c (0 = first cycle after accept) of byte b.
    task automatic chk_byte_cycle(input string tag, input logic [7:0] b, input int c);
        int  ph;
        int  bi;
        int  want;
        bit  sym;
        string t;
        ph   = c % SPS;
        bi   = 7 - c / SPS;
        want = 0;
        t    = $sformatf("%s_c%0d", tag, c);
        if (ph == 0) begin
            sym = b[bi];
`ifdef SYMBOL_UPSAMPLER_DIFF_EN
            sym      = sym ^ ref_prev;
            ref_prev = sym;
`endif
            want = sym ? AMP : -AMP;
        end
        chk({t, "_out"}, int'(out), want);
        chk({t, "_strobe"}, int'(out_strobe), (ph == 0) ? 1 : 0);
        chk({t, "_ready"}, int'(in_ready), (c == BYTE_CYC - 1) ? 1 : 0);
        chk({t, "_busy"}, int'(busy), 1);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) chk({tag, "_ready_timeout"}, 0, 1);
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b);
        wait_ready(tag);
        in_data  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int c = 0; c < BYTE_CYC; c++) begin
            chk_byte_cycle(tag, b, c);
            tick();
        end
        chk_idle({tag, "_after"}, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Held in reset with valid data presented
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk_idle($sformatf("rst_hold%0d", i), 0);
        end

        // Release; ready is withheld for the first cycle
        in_valid = 1'b0;
        in_data  = 8'h00;
        rst_n    = 1'b1;
        ref_prev = 1'b0;
        chk_idle("arm_c1", 0);
        tick();
        for (int i = 0; i < 200; i++) begin
            chk_idle($sformatf("idle%0d", i), 1);
            tick();
        end

        send_byte("a5", 8'hA5);

        // Back-to-back 00 then FF with in_valid held high
        wait_ready("b2b");
        in_data  = 8'h00;
        in_valid = 1'b1;
        tick();
        for (int c = 0; c < 2 * BYTE_CYC; c++) begin
            chk_byte_cycle((c < BYTE_CYC) ? "b2b_00" : "b2b_ff",
                           (c < BYTE_CYC) ? 8'h00 : 8'hFF, c % BYTE_CYC);
            if (c == BYTE_CYC - 1) in_data = 8'hFF;
            if (c == BYTE_CYC) in_valid = 1'b0;
            tick();
        end
        chk_idle("b2b_after", 1);

        // Asynchronous reset in the middle of a byte
        wait_ready("mid");
        in_data  = 8'hF0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            chk_byte_cycle("mid_f0", 8'hF0, c);
            if (c < 10) tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("mid_async", 0);
        ref_prev = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_idle($sformatf("mid_hold%0d", i), 0);
        end
        rst_n = 1'b1;
        chk_idle("mid_arm_c1", 0);
        tick();
        chk_idle("mid_arm_c2", 1);
        send_byte("post_80", 8'h80);

        // Fresh reset, then FF followed by 00
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        ref_prev = 1'b0;
        tick();
        send_byte("seq_ff", 8'hFF);
        send_byte("seq_00", 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
